regfile_wr_sequencer: RTL and testbench
=======================================

// Module: regfile_wr_sequencer
// PURPOSE
//  Write-side sequencer for the banked barrel-thread register file (regfile_vec). It owns the RF write port:
//  - zero-fills all NUM_THREADS*32 entries after reset, which also keeps x0 = 0 for every thread;
//  - merges pipeline writeback with a buffered host/debug write channel;
//  - suppresses every write to x0.
//  Sits between the writeback stage / debug bridge and the regfile_vec write port.
// PARAMETERS
//  NUM_THREADS  16  hardware threads; power of two >= 2; TW = $clog2(NUM_THREADS)
//  DWIDTH       32  register data width
//  HQ_DEPTH     4   host write FIFO depth; power of two >= 2
// PORTS
//  clk              in   1       core clock
//  i_rst_n          in   1       asynchronous active-low reset
//  i_wb_en          in   1       pipeline writeback request; no backpressure
//  i_wb_thread      in   TW      writeback thread index
//  i_wb_addr        in   5       writeback destination register
//  i_wb_data        in   DWIDTH  writeback data
//  i_host_valid     in   1       host write request
//  o_host_ready     out  1       host FIFO can accept
//  i_host_thread    in   TW      host thread index
//  i_host_addr      in   5       host destination register
//  i_host_data      in   DWIDTH  host write data
//  o_rf_wr_en       out  1       drives regfile_vec i_wr_en
//  o_rf_thread      out  TW      drives i_thread_index_writeback
//  o_rf_addr        out  5       drives i_write_addr
//  o_rf_data        out  DWIDTH  drives i_write_data
//  o_init_done      out  1       1 once the zero-fill sweep is complete
//  o_host_stall_cnt out  16      see CONFIGURATION
// BEHAVIOUR
//  Reset: all outputs 0. State = INIT, sweep counter = 0, FIFO empty. Counter and FIFO pointers also reset to 0.
//  INIT, one entry per cycle:
//  - o_rf_wr_en=1, {o_rf_thread,o_rf_addr}=counter, o_rf_data=0.
//  - Counter runs 0..NUM_THREADS*32-1. On the last entry, next state = RUN and o_init_done rises the following cycle.
//  - i_wb_en is ignored (dropped) in INIT.
//  - Host pushes are accepted in INIT but are not drained until RUN.
//  RUN: every cycle, at most one RF write, chosen by strict priority:
//  - 1: pipeline write, when i_wb_en=1 and i_wb_addr!=0;
//  - 2: head of host FIFO, when the FIFO is non-empty and no pipeline write was taken this cycle.
//  - i_wb_en with addr 0 is a no-op and leaves the slot free for the host.
//  - A host head with addr 0 is popped and discarded, with o_rf_wr_en=0.
//  Output timing:
//  - All o_rf_* outputs are registered; latency is 1 cycle from the input cycle to the write-port cycle.
//  - o_rf_wr_en=0 on idle cycles; o_rf_thread/o_rf_addr/o_rf_data then hold their last values.
//  Host channel:
//  - Push when i_host_valid && o_host_ready.
//  - o_host_ready = !full. It is registered-free, driven combinationally from the pointers.
//  - When full, ready=0 even if a pop happens the same cycle.
//  - Simultaneous push+pop when not full leaves the count unchanged.
//  - Order is strict FIFO; pointers wrap modulo HQ_DEPTH and use an extra wrap bit for full/empty.
//  Reset asserted mid-INIT or mid-RUN:
//  - the sweep restarts from 0;
//  - FIFO contents are lost;
//  - o_init_done drops immediately.
// CONFIGURATION
//  REGFILE_HOST_STALL_CNT_EN defined:
//  - o_host_stall_cnt is a 16-bit saturating counter, reset 0.
//  - It increments each RUN cycle in which the FIFO is non-empty and a pipeline write takes the port.
//  - It holds at 16'hFFFF.
//  Not defined: o_host_stall_cnt is tied to 16'h0 and no counter logic is built.
// TESTING
//  1. Release reset with NUM_THREADS=16:
//     - exactly 512 consecutive writes of 0 to addresses 0..511;
//     - o_init_done=1 on the cycle after the last write;
//     - o_rf_wr_en=0 afterwards.
//  2. RUN, i_wb_en=1, thread 3, addr 5, data 32'hDEADBEEF:
//     - one cycle later o_rf_wr_en=1, o_rf_thread=3, o_rf_addr=5, o_rf_data=DEADBEEF;
//     - the same stimulus with addr 0 gives o_rf_wr_en=0.
//  3. Host pushes 4 entries (A1..A4) while i_wb_en=1 with addr!=0 every cycle:
//     - o_host_ready=0 after the 4th push;
//     - no host write issues;
//     - with the macro defined, the stall count increments each cycle.
//  4. Drop i_wb_en:
//     - A1..A4 are written on 4 consecutive cycles in order;
//     - ready returns to 1 after the first pop.
//  5. Host push during INIT: the write appears only after o_init_done=1 and is not overwritten by the sweep.
//  6. Assert i_rst_n low at sweep count 100:
//     - all outputs 0 immediately;
//     - after release the sweep restarts at address 0;
//     - host entry with addr 0 is popped with no write.

Source files
------------

// File: rtl/regfile_wr_sequencer.sv
// Write-port sequencer for regfile_vec: post-reset zero-fill sweep, then writeback/host merge with x0 suppression.
// Optional host stall counter built when REGFILE_HOST_STALL_CNT_EN is defined.
module regfile_wr_sequencer #(
    parameter int unsigned NUM_THREADS = 16,
    parameter int unsigned DWIDTH      = 32,
    parameter int unsigned HQ_DEPTH    = 4
) (
    input  logic                           clk,
    input  logic                           i_rst_n,
    input  logic                           i_wb_en,
    input  logic [$clog2(NUM_THREADS)-1:0] i_wb_thread,
    input  logic [4:0]                     i_wb_addr,
    input  logic [DWIDTH-1:0]              i_wb_data,
    input  logic                           i_host_valid,
    output logic                           o_host_ready,
    input  logic [$clog2(NUM_THREADS)-1:0] i_host_thread,
    input  logic [4:0]                     i_host_addr,
    input  logic [DWIDTH-1:0]              i_host_data,
    output logic                           o_rf_wr_en,
    output logic [$clog2(NUM_THREADS)-1:0] o_rf_thread,
    output logic [4:0]                     o_rf_addr,
    output logic [DWIDTH-1:0]              o_rf_data,
    output logic                           o_init_done,
    output logic [15:0]                    o_host_stall_cnt
);

    localparam int unsigned TW = $clog2(NUM_THREADS);
    localparam int unsigned AW = 5;
    localparam int unsigned IW = TW + AW;
    localparam int unsigned QW = $clog2(HQ_DEPTH);
    localparam int unsigned PW = QW + 1;
    localparam int unsigned HW = TW + AW + DWIDTH;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_THREADS * 32 - 1);

    typedef enum logic {S_INIT, S_RUN} state_e;

    state_e            state_q, state_d;
    logic [IW-1:0]     sweep_q, sweep_d;
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [HW-1:0]     fifo_mem [HQ_DEPTH];
    logic              fifo_empty, fifo_full, push, pop, wb_take;
    logic [TW-1:0]     head_thread;
    logic [AW-1:0]     head_addr;
    logic [DWIDTH-1:0] head_data;
    logic              wr_en_d;
    logic [TW-1:0]     thread_d;
    logic [AW-1:0]     addr_d;
    logic [DWIDTH-1:0] data_d;

    // Extra wrap bit distinguishes full from empty when the index bits match.
    assign fifo_empty   = (wr_ptr_q == rd_ptr_q);
    assign fifo_full    = (wr_ptr_q[QW] != rd_ptr_q[QW]) && (wr_ptr_q[QW-1:0] == rd_ptr_q[QW-1:0]);
    assign o_host_ready = !fifo_full;
    assign push         = i_host_valid && !fifo_full;
    assign wb_take      = i_wb_en && (i_wb_addr != '0);
    assign {head_thread, head_addr, head_data} = fifo_mem[rd_ptr_q[QW-1:0]];

    // Next-state and write-port selection.
    always_comb begin
        state_d  = state_q;
        sweep_d  = sweep_q;
        pop      = 1'b0;
        wr_en_d  = 1'b0;
        thread_d = o_rf_thread;
        addr_d   = o_rf_addr;
        data_d   = o_rf_data;
        case (state_q)
            S_INIT: begin
                wr_en_d            = 1'b1;
                {thread_d, addr_d} = sweep_q;
                data_d             = '0;
                sweep_d            = sweep_q + IW'(1);
                if (sweep_q == LAST_IDX) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (wb_take) begin
                    wr_en_d  = 1'b1;
                    thread_d = i_wb_thread;
                    addr_d   = i_wb_addr;
                    data_d   = i_wb_data;
                end else if (!fifo_empty) begin
                    // x0 entries are consumed without a write.
                    pop = 1'b1;
                    if (head_addr != '0) begin
                        wr_en_d  = 1'b1;
                        thread_d = head_thread;
                        addr_d   = head_addr;
                        data_d   = head_data;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_INIT;
            sweep_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            o_rf_wr_en  <= 1'b0;
            o_rf_thread <= '0;
            o_rf_addr   <= '0;
            o_rf_data   <= '0;
            o_init_done <= 1'b0;
        end else begin
            state_q     <= state_d;
            sweep_q     <= sweep_d;
            o_rf_wr_en  <= wr_en_d;
            o_rf_thread <= thread_d;
            o_rf_addr   <= addr_d;
            o_rf_data   <= data_d;
            o_init_done <= (state_q == S_RUN);
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

    // Payload storage needs no reset; validity lives in the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q[QW-1:0]] <= {i_host_thread, i_host_addr, i_host_data};
        end
    end

`ifdef REGFILE_HOST_STALL_CNT_EN
    logic stall_inc;
    assign stall_inc = (state_q == S_RUN) && wb_take && !fifo_empty;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_host_stall_cnt <= '0;
        end else if (stall_inc && (o_host_stall_cnt != 16'hFFFF)) begin
            o_host_stall_cnt <= o_host_stall_cnt + 16'd1;
        end
    end
`else
    assign o_host_stall_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_regfile_wr_sequencer.sv
// Self-checking bench for regfile_wr_sequencer against a queue-based transaction model.
module tb_regfile_wr_sequencer;

    localparam int unsigned NUM_THREADS = 16;
    localparam int unsigned DWIDTH      = 32;
    localparam int unsigned HQ_DEPTH    = 4;
    localparam int unsigned TW          = $clog2(NUM_THREADS);
    localparam int unsigned IW          = TW + 5;
    localparam int unsigned ENTRIES     = NUM_THREADS * 32;

    logic              clk = 1'b0;
    logic              i_rst_n;
    logic              i_wb_en;
    logic [TW-1:0]     i_wb_thread;
    logic [4:0]        i_wb_addr;
    logic [DWIDTH-1:0] i_wb_data;
    logic              i_host_valid;
    logic              o_host_ready;
    logic [TW-1:0]     i_host_thread;
    logic [4:0]        i_host_addr;
    logic [DWIDTH-1:0] i_host_data;
    logic              o_rf_wr_en;
    logic [TW-1:0]     o_rf_thread;
    logic [4:0]        o_rf_addr;
    logic [DWIDTH-1:0] o_rf_data;
    logic              o_init_done;
    logic [15:0]       o_host_stall_cnt;

    regfile_wr_sequencer #(
        .NUM_THREADS(NUM_THREADS), .DWIDTH(DWIDTH), .HQ_DEPTH(HQ_DEPTH)
    ) dut (
        .clk(clk), .i_rst_n(i_rst_n),
        .i_wb_en(i_wb_en), .i_wb_thread(i_wb_thread), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
        .i_host_valid(i_host_valid), .o_host_ready(o_host_ready),
        .i_host_thread(i_host_thread), .i_host_addr(i_host_addr), .i_host_data(i_host_data),
        .o_rf_wr_en(o_rf_wr_en), .o_rf_thread(o_rf_thread), .o_rf_addr(o_rf_addr), .o_rf_data(o_rf_data),
        .o_init_done(o_init_done), .o_host_stall_cnt(o_host_stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [TW-1:0]     thread;
        logic [4:0]        addr;
        logic [DWIDTH-1:0] data;
    } hreq_t;

    // Reference model state
    hreq_t             host_q[$];
    bit                m_init;
    int                sweep;
    bit                e_wr;
    logic [TW-1:0]     e_thread;
    logic [4:0]        e_addr;
    logic [DWIDTH-1:0] e_data;
    bit                e_done;
    logic [15:0]       e_stall;

    int checks = 0;
    int errors = 0;

    task automatic model_reset();
        host_q.delete();
        m_init = 1'b1; sweep = 0;
        e_wr = 1'b0; e_thread = '0; e_addr = '0; e_data = '0; e_done = 1'b0; e_stall = '0;
    endtask

    task automatic idle_inputs();
        i_wb_en = 1'b0; i_wb_thread = '0; i_wb_addr = '0; i_wb_data = '0;
        i_host_valid = 1'b0; i_host_thread = '0; i_host_addr = '0; i_host_data = '0;
    endtask

    task automatic rand_inputs(input int unsigned wb_pct, input int unsigned host_pct);
        i_wb_en       = ($urandom_range(99) < wb_pct);
        i_wb_thread   = TW'($urandom);
        i_wb_addr     = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom);
        i_wb_data     = $urandom;
        i_host_valid  = ($urandom_range(99) < host_pct);
        i_host_thread = TW'($urandom);
        i_host_addr   = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom);
        i_host_data   = $urandom;
    endtask

    // One clock: advance the model with the inputs present at the edge, then settle.
    task automatic tick();
        hreq_t h;
        bit was_run, full_pre;
        @(posedge clk);
        was_run  = !m_init;
        full_pre = (host_q.size() >= HQ_DEPTH);
        e_wr     = 1'b0;
        if (m_init) begin
            e_wr = 1'b1;
            {e_thread, e_addr} = IW'(sweep);
            e_data = '0;
            if (sweep == ENTRIES - 1) m_init = 1'b0;
            else sweep++;
        end else if (i_wb_en && i_wb_addr != 5'd0) begin
            e_wr = 1'b1; e_thread = i_wb_thread; e_addr = i_wb_addr; e_data = i_wb_data;
`ifdef REGFILE_HOST_STALL_CNT_EN
            if (host_q.size() != 0 && e_stall != 16'hFFFF) e_stall++;
`endif
        end else if (host_q.size() != 0) begin
            h = host_q.pop_front();
            if (h.addr != 5'd0) begin
                e_wr = 1'b1; e_thread = h.thread; e_addr = h.addr; e_data = h.data;
            end
        end
        if (i_host_valid && !full_pre) host_q.push_back({i_host_thread, i_host_addr, i_host_data});
        e_done = was_run;
        #1;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        idle_inputs();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({o_rf_wr_en, o_rf_thread, o_rf_addr, o_rf_data} !== '0) begin
            errors++; $display("FAIL reset_port got %h required 0", {o_rf_wr_en, o_rf_thread, o_rf_addr, o_rf_data});
        end
        checks++;
        if (o_init_done !== 1'b0 || o_host_stall_cnt !== 16'h0) begin
            errors++; $display("FAIL reset_status got done=%b stall=%h required 0/0", o_init_done, o_host_stall_cnt);
        end
        i_rst_n = 1'b1;
        checks++;
        if (o_host_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready got %b required 1", o_host_ready);
        end
    endtask

    task automatic test_init_sweep();
        int seen = 0;
        for (int c = 0; c < ENTRIES + 4; c++) begin
            rand_inputs(60, 0);
            tick();
            if (o_rf_wr_en === 1'b1 && o_init_done === 1'b0) begin
                checks++;
                if ({o_rf_thread, o_rf_addr} !== IW'(seen) || o_rf_data !== '0) begin
                    errors++; $display("FAIL sweep_order got idx=%0d data=%h required idx=%0d data=0",
                                       {o_rf_thread, o_rf_addr}, o_rf_data, seen);
                end
                seen++;
            end
            checks++;
            if ({o_rf_wr_en, o_rf_thread, o_rf_addr, o_rf_data, o_init_done} !== {e_wr, e_thread, e_addr, e_data, e_done}) begin
                errors++; $display("FAIL sweep_port cyc %0d got %b/%h/%h/%h/%b required %b/%h/%h/%h/%b", c,
                                   o_rf_wr_en, o_rf_thread, o_rf_addr, o_rf_data, o_init_done,
                                   e_wr, e_thread, e_addr, e_data, e_done);
            end
        end
        checks++;
        if (seen != ENTRIES) begin
            errors++; $display("FAIL sweep_count got %0d required %0d", seen, ENTRIES);
        end
    endtask

    task automatic test_wb_write();
        idle_inputs();
        i_wb_en = 1'b1; i_wb_thread = TW'(3); i_wb_addr = 5'd5; i_wb_data = 32'hDEADBEEF;
        tick();
        checks++;
        if ({o_rf_wr_en, o_rf_thread, o_rf_addr, o_rf_data} !== {1'b1, TW'(3), 5'd5, 32'hDEADBEEF}) begin
            errors++; $display("FAIL wb_write got %b/%h/%h/%h required 1/3/05/deadbeef",
                               o_rf_wr_en, o_rf_thread, o_rf_addr, o_rf_data);
        end
        i_wb_addr = 5'd0;
        tick();
        checks++;
        if (o_rf_wr_en !== 1'b0 || o_rf_addr !== 5'd5 || o_rf_data !== 32'hDEADBEEF) begin
            errors++; $display("FAIL wb_x0 got en=%b addr=%h data=%h required 0/05/deadbeef", o_rf_wr_en, o_rf_addr, o_rf_data);
        end
    endtask

    task automatic test_host_fill_drain();
        logic [15:0] stall0;
        stall0 = o_host_stall_cnt;
        for (int k = 0; k < 4; k++) begin
            i_wb_en = 1'b1; i_wb_thread = TW'(k + 1); i_wb_addr = 5'(k + 10); i_wb_data = 32'h1000 + k;
            i_host_valid = 1'b1; i_host_thread = TW'(k + 8); i_host_addr = 5'(k + 1); i_host_data = 32'hA000_0001 + k;
            tick();
            checks++;
            if ({o_rf_wr_en, o_rf_thread, o_rf_addr, o_rf_data} !== {1'b1, TW'(k + 1), 5'(k + 10), 32'h1000 + k}) begin
                errors++; $display("FAIL fill_wb_priority push %0d got %h/%h/%h", k, o_rf_thread, o_rf_addr, o_rf_data);
            end
        end
        i_host_valid = 1'b0;
        checks++;
        if (o_host_ready !== 1'b0) begin
            errors++; $display("FAIL fill_ready got %b required 0", o_host_ready);
        end
`ifdef REGFILE_HOST_STALL_CNT_EN
        checks++;
        if (o_host_stall_cnt !== stall0 + 16'd3) begin
            errors++; $display("FAIL fill_stall got %0d required %0d", o_host_stall_cnt, stall0 + 16'd3);
        end
`else
        checks++;
        if (o_host_stall_cnt !== 16'h0 || stall0 !== 16'h0) begin
            errors++; $display("FAIL stall_tied got %h required 0", o_host_stall_cnt);
        end
`endif
        i_wb_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if ({o_rf_wr_en, o_rf_thread, o_rf_addr, o_rf_data} !== {1'b1, TW'(k + 8), 5'(k + 1), 32'hA000_0001 + k}) begin
                errors++; $display("FAIL drain_order A%0d got %b/%h/%h/%h", k + 1, o_rf_wr_en, o_rf_thread, o_rf_addr, o_rf_data);
            end
            checks++;
            if (o_host_ready !== 1'b1) begin
                errors++; $display("FAIL drain_ready A%0d got %b required 1", k + 1, o_host_ready);
            end
        end
        tick();
        checks++;
        if (o_rf_wr_en !== 1'b0 || host_q.size() != 0) begin
            errors++; $display("FAIL drain_idle got en=%b q=%0d required 0/0", o_rf_wr_en, host_q.size());
        end
    endtask

    task automatic test_random_mix(input int cycles, input int unsigned wb_pct, input int unsigned host_pct);
        for (int c = 0; c < cycles; c++) begin
            rand_inputs(wb_pct, host_pct);
            checks++;
            if (o_host_ready !== (host_q.size() < HQ_DEPTH)) begin
                errors++; $display("FAIL rand_ready cyc %0d got %b q=%0d", c, o_host_ready, host_q.size());
            end
            tick();
            checks++;
            if ({o_rf_wr_en, o_rf_thread, o_rf_addr, o_rf_data, o_init_done, o_host_stall_cnt} !==
                {e_wr, e_thread, e_addr, e_data, e_done, e_stall}) begin
                errors++; $display("FAIL rand_port cyc %0d got %b/%h/%h/%h/%b/%h required %b/%h/%h/%h/%b/%h", c,
                                   o_rf_wr_en, o_rf_thread, o_rf_addr, o_rf_data, o_init_done, o_host_stall_cnt,
                                   e_wr, e_thread, e_addr, e_data, e_done, e_stall);
            end
        end
    endtask

    task automatic test_init_push();
        int guard = 0;
        bit seen_early = 1'b0;
        bit found = 1'b0;
        logic [TW-1:0] t;
        t = TW'($urandom);
        test_reset();
        idle_inputs();
        i_host_valid = 1'b1; i_host_thread = t; i_host_addr = 5'd7; i_host_data = 32'hC0FFEE01;
        tick();
        idle_inputs();
        while (!found && guard < ENTRIES + 20) begin
            tick();
            guard++;
            if (o_rf_wr_en === 1'b1 && o_rf_data === 32'hC0FFEE01) begin
                found = 1'b1;
                if (o_init_done !== 1'b1) seen_early = 1'b1;
            end
        end
        checks++;
        if (!found || seen_early) begin
            errors++; $display("FAIL init_push found=%b early=%b after %0d cycles", found, seen_early, guard);
        end
        checks++;
        if ({o_rf_thread, o_rf_addr} !== {t, 5'd7} || e_data !== 32'hC0FFEE01) begin
            errors++; $display("FAIL init_push_dest got %h/%h required %h/07", o_rf_thread, o_rf_addr, t);
        end
    endtask

    task automatic test_reset_mid();
        test_reset();
        idle_inputs();
        repeat (100) tick();
        i_rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({o_rf_wr_en, o_rf_thread, o_rf_addr, o_rf_data, o_init_done, o_host_stall_cnt} !== '0) begin
            errors++; $display("FAIL midreset_zero got %b/%h/%h/%h/%b/%h", o_rf_wr_en, o_rf_thread, o_rf_addr,
                               o_rf_data, o_init_done, o_host_stall_cnt);
        end
        @(posedge clk); #1;
        i_rst_n = 1'b1;
        i_host_valid = 1'b1; i_host_thread = TW'(2); i_host_addr = 5'd0; i_host_data = 32'h5555AAAA;
        tick();
        i_host_thread = TW'(9); i_host_addr = 5'd31; i_host_data = 32'h1234_5678;
        tick();
        checks++;
        if ({o_rf_wr_en, o_rf_thread, o_rf_addr, o_rf_data} !== {1'b1, TW'(0), 5'd1, 32'h0}) begin
            errors++; $display("FAIL midreset_restart got %b/%h/%h/%h required 1/0/01/0",
                               o_rf_wr_en, o_rf_thread, o_rf_addr, o_rf_data);
        end
        idle_inputs();
        test_random_mix(ENTRIES + 8, 0, 0);
        checks++;
        if (host_q.size() != 0 || o_rf_data !== 32'h1234_5678) begin
            errors++; $display("FAIL midreset_x0_pop got q=%0d last_data=%h required 0/12345678", host_q.size(), o_rf_data);
        end
    endtask

    initial begin
        test_reset();
        test_init_sweep();
        test_wb_write();
        test_host_fill_drain();
        test_random_mix(1500, 50, 50);
        test_random_mix(600, 90, 80);
        test_init_push();
        test_random_mix(300, 40, 60);
        test_reset_mid();
        test_random_mix(400, 30, 70);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1);
    end

endmodule
